// File: rtl/edge_event_recorder.sv
// -----------------------------------------------------------------------------
// edge_event_recorder
//
// Watches a single-bit signal d and records every level change while en is
// high. Each record is {new level, timestamp} taken from a free-running
// counter. Records are queued in a small FIFO and presented to the consumer
// with a valid/ready handshake. A sticky overflow flag marks any record that
// was lost because the FIFO was full and nothing was popped in that cycle.
//
// Optional feature:
//   EDGE_REC_SYNC_EN - when defined, d passes through a two-flop synchronizer
//                      before the sampling register. This adds 2 cycles of
//                      latency, so timestamps read 2 higher relative to the
//                      d transition. When undefined, d is taken as
//                      synchronous to clk.
//
// Parameters:
//   TS_W  - timestamp counter width (wraps silently)
//   DEPTH - FIFO depth in entries (power of 2, >= 2)
//
// Ports:
//   clk       in   single clock, rising edge
//   rst_n     in   synchronous active-low reset
//   d         in   monitored signal
//   en        in   recording enable
//   clr_ovf   in   synchronous clear of overflow (a same-cycle drop wins)
//   out_valid out  FIFO head holds a record
//   out_ready in   consumer accepts head record
//   out_data  out  head record: [TS_W] = level, [TS_W-1:0] = timestamp
//   count     out  number of records held
//   overflow  out  sticky: a record was dropped
// -----------------------------------------------------------------------------
module edge_event_recorder #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   d,
    input  logic                   en,
    input  logic                   clr_ovf,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TS_W:0]          out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic [TS_W-1:0] ts_r;
    logic            d_in_s;
    logic            d_samp_r;
    logic            d_prev_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            valid_r;
    logic            ovf_r;
    logic [TS_W:0]   mem_r [DEPTH];

    logic            edge_s;
    logic            push_s;
    logic            pop_s;
    logic            full_s;
    logic            wr_ok_s;
    logic            drop_s;
    logic [CW-1:0]   count_next_s;
    logic            ovf_next_s;

`ifdef EDGE_REC_SYNC_EN
    logic sync1_r;
    logic sync2_r;

    // Two-flop synchronizer for an asynchronous d.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= d;
            sync2_r <= sync1_r;
        end
    end

    assign d_in_s = sync2_r;
`else
    assign d_in_s = d;
`endif

    // Edge detection, FIFO handshake decisions and next count/overflow.
    always_comb begin
        edge_s       = d_samp_r ^ d_prev_r;
        push_s       = edge_s & en;
        pop_s        = valid_r & out_ready;
        full_s       = (count_r == FULL_CNT);
        // A full FIFO still accepts a push when the head leaves in the same
        // cycle: the write lands on the slot being vacated.
        wr_ok_s      = push_s & (~full_s | pop_s);
        drop_s       = push_s & full_s & ~pop_s;
        count_next_s = count_r;
        ovf_next_s   = ovf_r;

        case ({wr_ok_s, pop_s})
            2'b10:   count_next_s = count_r + ONE_CNT;
            2'b01:   count_next_s = count_r - ONE_CNT;
            default: count_next_s = count_r;
        endcase

        // A drop in the same cycle as clr_ovf keeps the flag set.
        if (drop_s) begin
            ovf_next_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // Timestamp, sampling registers, pointers, occupancy and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_r     <= '0;
            d_samp_r <= 1'b0;
            d_prev_r <= 1'b0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            ts_r     <= ts_r + TS_W'(1);
            d_samp_r <= d_in_s;
            // d_prev follows regardless of en so re-enabling sees no stale edge.
            d_prev_r <= d_samp_r;
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r  <= count_next_s;
            valid_r  <= (count_next_s != '0);
            ovf_r    <= ovf_next_s;
        end
    end

    // Record storage; contents are don't-care whenever count says empty.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok_s) begin
            mem_r[wr_ptr_r] <= {d_samp_r, ts_r};
        end
    end

    assign out_valid = valid_r;
    assign out_data  = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_edge_event_recorder.sv
// -----------------------------------------------------------------------------
// tb_edge_event_recorder
//
// Drives two recorders (TS_W=16 and TS_W=4, both DEPTH=8) from the same
// stimulus. Expected records are queued when d is changed; a monitor pops
// and compares each record the DUT hands over on a valid/ready beat.
// -----------------------------------------------------------------------------
module tb_edge_event_recorder;

`ifdef EDGE_REC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        d;
    logic        en;
    logic        clr_ovf;
    logic        out_ready;
    logic        out_valid;
    logic [16:0] out_data;
    logic [3:0]  count;
    logic        overflow;
    logic        out_valid4;
    logic [4:0]  out_data4;
    logic [3:0]  count4;
    logic        overflow4;

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned ts_m     = 0;
    logic [16:0] q16 [$];
    logic [4:0]  q4  [$];

    edge_event_recorder #(.TS_W(16), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .en(en), .clr_ovf(clr_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .overflow(overflow)
    );

    edge_event_recorder #(.TS_W(4), .DEPTH(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .d(d), .en(en), .clr_ovf(clr_ovf),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .count(count4), .overflow(overflow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference timestamp: cleared by reset, +1 every other edge.
    always @(posedge clk) begin
        ts_m <= rst_n ? ts_m + 1 : 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic exp_push(input logic lvl, input int unsigned t);
        q16.push_back({lvl, t[15:0]});
        q4.push_back({lvl, t[3:0]});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Flip d; the record carries the timestamp of the detection cycle.
    task automatic toggle(input bit keep);
        d = ~d;
        if (keep) exp_push(d, ts_m + LAT);
        step(2);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (count == 4'd0) break;
        end
        chk("drain_done", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Monitor: compare every accepted head record with the scoreboard.
    always @(negedge clk) begin
        logic [16:0] e16;
        logic [4:0]  e4;
        if (rst_n && out_valid && out_ready) begin
            if (q16.size() == 0) begin
                n_checks++;
                $display("FAIL mon16_unexpected: got %0h required no record", out_data);
            end else begin
                e16 = q16.pop_front();
                chk("mon16_data", 32'(out_data), 32'(e16));
            end
        end
        if (rst_n && out_valid4 && out_ready) begin
            if (q4.size() == 0) begin
                n_checks++;
                $display("FAIL mon4_unexpected: got %0h required no record", out_data4);
            end else begin
                e4 = q4.pop_front();
                chk("mon4_data", 32'(out_data4), 32'(e4));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got hang required finish");
        $fatal(1);
    end

    initial begin
        d = 1'b0; en = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        step(3);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_count4", 32'(count4), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;

        // Single rising edge at ts=5 and its latency.
        for (int i = 0; i < 20 && ts_m != 5; i++) step(1);
        d = 1'b1;
        exp_push(1'b1, ts_m + LAT);
        for (int i = 0; i <= LAT; i++) begin
            @(negedge clk);
            chk("lat_not_yet", 32'(out_valid), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_count", 32'(count), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Nine edges into an 8-deep FIFO with no consumer.
        en = 1'b0; d = 1'b0;
        step(LAT + 3);
        en = 1'b1;
        for (int k = 1; k <= 9; k++) toggle(k <= 8);
        step(LAT);
        @(negedge clk);
        chk("ovfl_count", 32'(count), 32'd8);
        chk("ovfl_flag", 32'(overflow), 32'd1);
        chk("ovfl_count4", 32'(count4), 32'd8);
        chk("ovfl_flag4", 32'(overflow4), 32'd1);
        @(posedge clk);
        #1;
        drain();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;

        // Drop in the same cycle as clr_ovf: set wins.
        for (int k = 1; k <= 8; k++) toggle(1'b1);
        step(LAT);
        d = ~d;
        step(LAT);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        @(negedge clk);
        chk("set_wins_ovf", 32'(overflow), 32'd1);
        chk("set_wins_count", 32'(count), 32'd8);
        @(posedge clk);
        #1;
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        @(negedge clk);
        chk("clr_after_set", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;

        // Full FIFO, push and pop in the same cycle.
        d = ~d;
        exp_push(d, ts_m + LAT);
        step(LAT);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        @(negedge clk);
        chk("full_pp_count", 32'(count), 32'd8);
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        drain();
        chk("full_pp_sb_empty", 32'(q16.size()), 32'd0);

        // Edges while disabled, then re-enable with d steady.
        en = 1'b0;
        for (int k = 0; k < 3; k++) toggle(1'b0);
        step(LAT + 2);
        en = 1'b1;
        step(5);
        @(negedge clk);
        chk("dis_count", 32'(count), 32'd0);
        chk("dis_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Timestamp wrap on the 4-bit instance: 15 then 1.
        for (int i = 0; i < 20 && (ts_m % 16) != 14; i++) step(1);
        toggle(1'b1);
        toggle(1'b1);
        step(LAT);
        @(negedge clk);
        chk("wrap_count4", 32'(count4), 32'd2);
        chk("wrap_ovf4", 32'(overflow4), 32'd0);
        @(posedge clk);
        #1;
        drain();

        // Reset with count=5 and overflow=1, then d=1 after reset.
        for (int k = 1; k <= 9; k++) toggle(k <= 8);
        step(LAT);
        out_ready = 1'b1;
        step(3);
        out_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_count", 32'(count), 32'd5);
        chk("pre_rst_ovf", 32'(overflow), 32'd1);
        @(posedge clk);
        #1;
        d = 1'b1;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        q16.delete();
        q4.delete();
        exp_push(1'b1, ts_m + LAT);
        @(negedge clk);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_ovf4", 32'(overflow4), 32'd0);
        @(posedge clk);
        #1;
        step(LAT + 3);
        @(negedge clk);
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        drain();
        chk("end_sb16_empty", 32'(q16.size()), 32'd0);
        chk("end_sb4_empty", 32'(q4.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
